// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch: PC, single-outstanding imem requests, prefetch queue, IfId register
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (adds Misalign output, word-aligns redirect targets)
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          QDEPTH   = 2
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        Stall,
   input  logic        Flush,
   input  logic        FwdPc,
   input  logic [31:0] PCT,
   output logic        Imem_Req,
   output logic [31:0] Imem_Addr,
   input  logic        Imem_Ack,
   input  logic [31:0] Imem_Rdata,
   output logic [31:0] IfId_Instr,
   output logic [31:0] IfId_UpdatPC,
   output logic        IfId_Valid
`ifdef FETCH_MISALIGN_TRAP_EN
   ,
   output logic        Misalign
`endif
);

   localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
   localparam int CW = $clog2(QDEPTH + 1);
   localparam logic [PW-1:0] LAST_PTR = PW'(QDEPTH - 1);
   localparam logic [CW-1:0] DEPTH_C  = CW'(QDEPTH);

   // Request tracker: IDLE = nothing outstanding, BUSY = outstanding and wanted,
   // DROP = outstanding but superseded by a redirect (data is discarded on ack)
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DROP = 2'd2
   } req_state_t;

   req_state_t    r_state;
   req_state_t    w_state_next;

   logic [31:0]   r_pc;
   logic [31:0]   r_addr;
   logic [31:0]   r_q_instr [QDEPTH];
   logic [31:0]   r_q_upc   [QDEPTH];
   logic [PW-1:0] r_wptr;
   logic [PW-1:0] r_rptr;
   logic [CW-1:0] r_count;
   logic [31:0]   r_ifid_instr;
   logic [31:0]   r_ifid_upc;
   logic          r_ifid_valid;

   logic [31:0]   w_pct;
   logic [31:0]   w_pc_next;
   logic [CW-1:0] w_count_next;
   logic          w_push;
   logic          w_pop;
   logic          w_busy_next;
   logic          w_issue;

`ifdef FETCH_MISALIGN_TRAP_EN
   logic          r_misalign;
   logic          w_misalign_evt;

   assign w_pct          = {PCT[31:2], 2'b00};
   assign w_misalign_evt = FwdPc && (PCT[1:0] != 2'b00);
   assign Misalign       = r_misalign;
`else
   assign w_pct = PCT;
`endif

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == LAST_PTR) ? '0 : p + 1'b1;
   endfunction

   // A redirect discards any ack in the same cycle; a stalled or flushed IfId never pops
   always_comb begin
      w_push      = (r_state == S_BUSY) && Imem_Ack && !FwdPc;
      w_pop       = !FwdPc && !Flush && !Stall && (r_count != '0);
      w_busy_next = (r_state != S_IDLE) && !Imem_Ack;
      w_pc_next   = r_pc;
      if (FwdPc) begin
         w_pc_next = w_pct;
      end else if (w_push) begin
         w_pc_next = r_addr + 32'd4;
      end
      w_count_next = r_count;
      if (FwdPc) begin
         w_count_next = '0;
      end else if (w_push && !w_pop) begin
         w_count_next = r_count + 1'b1;
      end else if (!w_push && w_pop) begin
         w_count_next = r_count - 1'b1;
      end
      // new request only when none stays outstanding and the queue will have room for it
      w_issue = !w_busy_next && (w_count_next < DEPTH_C);
   end

   // Request tracker next state
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_issue) begin
               w_state_next = S_BUSY;
            end
         end
         S_BUSY: begin
            if (Imem_Ack) begin
               w_state_next = w_issue ? S_BUSY : S_IDLE;
            end else if (FwdPc) begin
               w_state_next = S_DROP;
            end
         end
         S_DROP: begin
            if (Imem_Ack) begin
               w_state_next = w_issue ? S_BUSY : S_IDLE;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // Request tracker state register
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Fetch PC and the held request address (stable until acked)
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_pc   <= RESET_PC;
         r_addr <= RESET_PC;
      end else begin
         r_pc <= w_pc_next;
         if (w_issue) begin
            r_addr <= w_pc_next;
         end
      end
   end

   // Circular prefetch queue of {instruction, address+4}
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         for (int i = 0; i < QDEPTH; i++) begin
            r_q_instr[i] <= '0;
            r_q_upc[i]   <= '0;
         end
      end else if (FwdPc) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_q_instr[r_wptr] <= Imem_Rdata;
            r_q_upc[r_wptr]   <= r_addr + 32'd4;
            r_wptr            <= ptr_inc(r_wptr);
         end
         if (w_pop) begin
            r_rptr <= ptr_inc(r_rptr);
         end
         r_count <= w_count_next;
      end
   end

   // IfId register: redirect/flush bubble, stall hold, else queue head or bubble
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_ifid_instr <= '0;
         r_ifid_upc   <= RESET_PC;
         r_ifid_valid <= 1'b0;
      end else if (FwdPc || Flush) begin
         r_ifid_instr <= '0;
         r_ifid_valid <= 1'b0;
      end else if (!Stall) begin
         if (r_count != '0) begin
            r_ifid_instr <= r_q_instr[r_rptr];
            r_ifid_upc   <= r_q_upc[r_rptr];
            r_ifid_valid <= 1'b1;
         end else begin
            r_ifid_instr <= '0;
            r_ifid_valid <= 1'b0;
         end
      end
   end

`ifdef FETCH_MISALIGN_TRAP_EN
   // Sticky misaligned-redirect flag, cleared only by reset
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_misalign <= 1'b0;
      end else if (w_misalign_evt) begin
         r_misalign <= 1'b1;
      end
   end
`endif

   assign Imem_Req     = (r_state != S_IDLE);
   assign Imem_Addr    = r_addr;
   assign IfId_Instr   = r_ifid_instr;
   assign IfId_UpdatPC = r_ifid_upc;
   assign IfId_Valid   = r_ifid_valid;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit (vector table plus redirect/flush/wrap/reset sequences)
module tb_fetch_unit;

   logic        CLK = 1'b0;
   logic        RST;
   logic        Stall, Flush, FwdPc, Imem_Ack;
   logic [31:0] PCT, Imem_Rdata;
   logic        Imem_Req, IfId_Valid;
   logic [31:0] Imem_Addr, IfId_Instr, IfId_UpdatPC;
`ifdef FETCH_MISALIGN_TRAP_EN
   logic        Misalign;
`endif

   int n_checks = 0;
   int n_err    = 0;

   fetch_unit #(.RESET_PC(32'h0000_0000), .QDEPTH(2)) dut (
      .CLK(CLK), .RST(RST), .Stall(Stall), .Flush(Flush), .FwdPc(FwdPc), .PCT(PCT),
      .Imem_Req(Imem_Req), .Imem_Addr(Imem_Addr), .Imem_Ack(Imem_Ack), .Imem_Rdata(Imem_Rdata),
      .IfId_Instr(IfId_Instr), .IfId_UpdatPC(IfId_UpdatPC), .IfId_Valid(IfId_Valid)
`ifdef FETCH_MISALIGN_TRAP_EN
      , .Misalign(Misalign)
`endif
   );

   always #5 CLK = ~CLK;

   function automatic logic [31:0] mem(input logic [31:0] a);
      return a ^ 32'h1357_9BDF;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic chk_if(input string nm, input logic v, input logic [31:0] ins, input logic [31:0] upc);
      chk({nm, ".valid"}, {31'd0, IfId_Valid}, {31'd0, v});
      chk({nm, ".instr"}, IfId_Instr, ins);
      chk({nm, ".upc"}, IfId_UpdatPC, upc);
   endtask

   // apply inputs at a falling edge, run one rising edge, return at the next falling edge
   task automatic tick(input logic st, input logic fl, input logic fw, input logic [31:0] pc, input logic ak);
      Stall      = st;
      Flush      = fl;
      FwdPc      = fw;
      PCT        = pc;
      Imem_Ack   = ak & Imem_Req;
      Imem_Rdata = ak ? mem(Imem_Addr) : 32'hDEAD_BEEF;
      @(posedge CLK);
      @(negedge CLK);
   endtask

   task automatic do_reset();
      RST = 1'b1; Stall = 0; Flush = 0; FwdPc = 0; PCT = 0; Imem_Ack = 0; Imem_Rdata = 0;
      @(posedge CLK);
      @(posedge CLK);
      @(negedge CLK);
      RST = 1'b0;
   endtask

   typedef struct {
      logic        st;
      logic        ak;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_valid;
      logic [31:0] e_instr;
      logic [31:0] e_upc;
   } vec_t;

   vec_t vt [12];

   initial begin
      // check the listed outputs, then apply {stall, ack} for the following edge
      vt[0]  = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0,   32'h0};
      vt[1]  = '{1'b0, 1'b1, 1'b1, 32'h0,  1'b0, 32'h0,   32'h0};
      vt[2]  = '{1'b0, 1'b1, 1'b1, 32'h4,  1'b0, 32'h0,   32'h0};
      vt[3]  = '{1'b0, 1'b1, 1'b1, 32'h8,  1'b1, mem(0),  32'h4};
      vt[4]  = '{1'b1, 1'b1, 1'b1, 32'hC,  1'b1, mem(4),  32'h8};
      vt[5]  = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b1, mem(4),  32'h8};
      vt[6]  = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b1, mem(4),  32'h8};
      vt[7]  = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b1, mem(4),  32'h8};
      vt[8]  = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b1, mem(4),  32'h8};
      vt[9]  = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b1, mem(4),  32'h8};
      vt[10] = '{1'b0, 1'b1, 1'b1, 32'h10, 1'b1, mem(8),  32'hC};
      vt[11] = '{1'b0, 1'b0, 1'b1, 32'h14, 1'b1, mem(12), 32'h10};

      do_reset();
      chk("rst.req", {31'd0, Imem_Req}, 32'd0);
      for (int i = 0; i < 12; i++) begin
         chk($sformatf("v%0d.req", i), {31'd0, Imem_Req}, {31'd0, vt[i].e_req});
         if (vt[i].e_req) chk($sformatf("v%0d.addr", i), Imem_Addr, vt[i].e_addr);
         chk_if($sformatf("v%0d", i), vt[i].e_valid, vt[i].e_instr, vt[i].e_upc);
         tick(vt[i].st, 1'b0, 1'b0, 32'h0, vt[i].ak);
      end

      // redirect while the 0x0C request is outstanding, ack three cycles later
      do_reset();
      repeat (4) tick(0, 0, 0, 32'h0, 1);
      chk("fwd.pre_addr", Imem_Addr, 32'hC);
      tick(0, 0, 1, 32'h100, 0);
      chk("fwd.hold_req", {31'd0, Imem_Req}, 32'd1);
      chk("fwd.hold_addr", Imem_Addr, 32'hC);
      chk_if("fwd.bubble", 1'b0, 32'h0, 32'h8);
      tick(0, 0, 0, 32'h0, 0);
      tick(0, 0, 0, 32'h0, 0);
      chk("fwd.hold_addr2", Imem_Addr, 32'hC);
      chk_if("fwd.bubble2", 1'b0, 32'h0, 32'h8);
      tick(0, 0, 0, 32'h0, 1);
      chk("fwd.new_addr", Imem_Addr, 32'h100);
      chk_if("fwd.drop", 1'b0, 32'h0, 32'h8);
      tick(0, 0, 0, 32'h0, 1);
      chk("fwd.addr104", Imem_Addr, 32'h104);
      chk_if("fwd.nobypass", 1'b0, 32'h0, 32'h8);
      tick(0, 0, 0, 32'h0, 1);
      chk_if("fwd.first", 1'b1, mem(32'h100), 32'h104);

      // flush with two queued words
      tick(1, 0, 0, 32'h0, 1);
      chk("fl.full_req", {31'd0, Imem_Req}, 32'd0);
      tick(0, 1, 0, 32'h0, 0);
      chk_if("fl.bubble", 1'b0, 32'h0, 32'h104);
      tick(0, 0, 0, 32'h0, 0);
      chk_if("fl.w0", 1'b1, mem(32'h104), 32'h108);
      chk("fl.addr", Imem_Addr, 32'h10C);
      tick(0, 0, 0, 32'h0, 0);
      chk_if("fl.w1", 1'b1, mem(32'h108), 32'h10C);

      // PC wrap from 0xFFFF_FFFC
      tick(0, 0, 1, 32'hFFFF_FFFC, 0);
      tick(0, 0, 0, 32'h0, 1);
      chk("wr.addr", Imem_Addr, 32'hFFFF_FFFC);
      tick(0, 0, 0, 32'h0, 1);
      chk("wr.next", Imem_Addr, 32'h0);
      tick(0, 0, 0, 32'h0, 0);
      chk_if("wr.ifid", 1'b1, mem(32'hFFFF_FFFC), 32'h0);

      // ack in the same cycle as a redirect is discarded
      tick(0, 0, 1, 32'h200, 1);
      chk("fa.addr", Imem_Addr, 32'h200);
      chk_if("fa.bubble", 1'b0, 32'h0, 32'h0);
      tick(0, 0, 0, 32'h0, 1);
      chk_if("fa.nopush", 1'b0, 32'h0, 32'h0);
      tick(0, 0, 0, 32'h0, 0);
      chk_if("fa.first", 1'b1, mem(32'h200), 32'h204);

      // asynchronous reset in the middle of a request
      #2 RST = 1'b1;
      #1;
      chk("ar.req", {31'd0, Imem_Req}, 32'd0);
      chk_if("ar.ifid", 1'b0, 32'h0, 32'h0);
      @(negedge CLK);
      RST = 1'b0;
      tick(0, 0, 0, 32'h0, 0);
      chk("ar.req1", {31'd0, Imem_Req}, 32'd1);
      chk("ar.addr", Imem_Addr, 32'h0);

`ifdef FETCH_MISALIGN_TRAP_EN
      tick(0, 0, 1, 32'h102, 1);
      chk("mis.flag", {31'd0, Misalign}, 32'd1);
      chk("mis.addr", Imem_Addr, 32'h100);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
